conv3x3_time_mux: RTL and testbench

//  Streaming 3x3 2-D convolution over a raster-scan greyscale image, one pixel per cycle.
//  Two line buffers plus a 3x3 window register feed a fixed Laplacian kernel MAC.

---
 rtl/conv3x3_time_mux.sv | 161 ++++++++++++++++
 tb/tb_conv3x3_time_mux.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_time_mux.sv
// Streaming 3x3 Laplacian convolution over a raster-scan greyscale image.
// Two line buffers hold the previous two rows; a 3x3 window register feeds a
// fixed-kernel multiply/accumulate split over three pipeline stages.
module conv3x3_time_mux #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 28,
    parameter int SHIFT      = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] pixel_out
);
    localparam int ACC_W = DATA_WIDTH + 5;
    localparam int CW    = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 2;
    localparam logic [CW-1:0] LAST_IDX = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] FIRST_OK = CW'(2);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (DATA_WIDTH - 1)));

    // Position of the next pixel to be accepted
    logic [CW-1:0] row_reg;
    logic [CW-1:0] col_reg;

    // lb0 holds row r-1, lb1 holds row r-2, indexed by column
    logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];

    // Stage 0: accepted pixel plus the two pixels above it
    logic [DATA_WIDTH-1:0] up1_reg;
    logic [DATA_WIDTH-1:0] up2_reg;
    logic [DATA_WIDTH-1:0] pix_reg;
    logic [CW-1:0]         wcol_reg;
    logic                  s0_valid_reg;
    logic                  s0_ok_reg;
    logic                  s1_valid_reg;
    logic                  s2_valid_reg;

    logic [DATA_WIDTH-1:0]   new_col [3];
    logic signed [ACC_W-1:0] row_sum [3];
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] shifted;
    logic [DATA_WIDTH-1:0]   sat_value;

    // Row/column tracking; only accepted pixels advance the raster position
    always_ff @(posedge clk) begin
        if (rst_n) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (valid_in) begin
            if (col_reg == LAST_IDX) begin
                col_reg <= '0;
                row_reg <= (row_reg == LAST_IDX) ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    // Pipeline valid bits; a window only counts once it lies entirely inside the image
    always_ff @(posedge clk) begin
        if (rst_n) begin
            s0_valid_reg <= 1'b0;
            s0_ok_reg    <= 1'b0;
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            s0_valid_reg <= valid_in;
            s0_ok_reg    <= valid_in && (row_reg >= FIRST_OK) && (col_reg >= FIRST_OK);
            s1_valid_reg <= s0_valid_reg && s0_ok_reg;
            s2_valid_reg <= s1_valid_reg;
        end
    end

    // Registered line-buffer read of the column above; new pixel written into lb0
    always_ff @(posedge clk) begin
        if (valid_in) begin
            up1_reg      <= lb0[col_reg];
            up2_reg      <= lb1[col_reg];
            lb0[col_reg] <= pixel_in;
            pix_reg      <= pixel_in;
            wcol_reg     <= col_reg;
        end
    end

    // The row displaced from lb0 ages into lb1 one cycle later, from registered data
    always_ff @(posedge clk) begin
        if (s0_valid_reg) begin
            lb1[wcol_reg] <= up1_reg;
        end
    end

    // Newest window column, top (r-2) to bottom (r)
    always_comb begin
        new_col[0] = up2_reg;
        new_col[1] = up1_reg;
        new_col[2] = pix_reg;
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : gen_row
            logic [DATA_WIDTH-1:0]   win_reg [3];
            logic signed [ACC_W-1:0] prod [3];
            logic signed [ACC_W-1:0] row_sum_reg;

            // S1: shift this window row left and insert the newest pixel on the right
            always_ff @(posedge clk) begin
                if (s0_valid_reg) begin
                    win_reg[0] <= win_reg[1];
                    win_reg[1] <= win_reg[2];
                    win_reg[2] <= new_col[gi];
                end
            end

            for (genvar gj = 0; gj < 3; gj++) begin : gen_col
                // Laplacian: 4 at centre, -1 at edge neighbours, 0 at corners
                localparam int KV = (gi == 1 && gj == 1) ? 4 :
                                    (((gi == 1) != (gj == 1)) ? -1 : 0);
                logic signed [ACC_W-1:0] pix_ext;
                assign pix_ext  = {{(ACC_W - DATA_WIDTH){1'b0}}, win_reg[gj]};
                assign prod[gj] = pix_ext * ACC_W'(KV);
            end

            // S2: per-row partial sum of the kernel products
            always_ff @(posedge clk) begin
                row_sum_reg <= prod[0] + prod[1] + prod[2];
            end

            assign row_sum[gi] = row_sum_reg;
        end
    endgenerate

    // S3 combinational part: final sum, scale and clamp to the signed output range
    always_comb begin
        acc     = row_sum[0] + row_sum[1] + row_sum[2];
        shifted = acc >>> SHIFT;
        if (shifted > SAT_MAX) begin
            sat_value = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_value = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            sat_value = shifted[DATA_WIDTH-1:0];
        end
    end

    // Output registers; pixel_out keeps the last result between pulses
    always_ff @(posedge clk) begin
        if (rst_n) begin
            valid_out <= 1'b0;
            pixel_out <= '0;
        end else begin
            valid_out <= s2_valid_reg;
            if (s2_valid_reg) begin
                pixel_out <= sat_value;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_time_mux.sv
// Directed bench for conv3x3_time_mux: ramp, saturation, gapped and reset frames.
module tb_conv3x3_time_mux;
    localparam int N = 28;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] pixel_in = 8'd0;
    logic       valid_out;
    logic [7:0] pixel_out;

    conv3x3_time_mux #(.DATA_WIDTH(8), .IMG_WIDTH(N), .SHIFT(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .pixel_in  (pixel_in),
        .valid_out (valid_out),
        .pixel_out (pixel_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [7:0] val;
        int         r;
        int         c;
    } exp_t;

    exp_t       exp_q[$];
    int         img [N][N];
    logic [7:0] out_img [N][N];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         tr = 0;
    int         tc = 0;
    int         pulses = 0;
    int         first_cyc = -1;
    int         acc22 = 0;
    int         frame_sum = 0;
    int         ramp_sum = 0;
    logic [7:0] last_out = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Image-level reference: Laplacian centred one row/col behind the completing pixel
    function automatic logic [7:0] model(input int r, input int c);
        int a;
        a = 4 * img[r-1][c-1] - img[r-2][c-1] - img[r][c-1] - img[r-1][c-2] - img[r-1][c];
        if (a > 127) a = 127;
        else if (a < -128) a = -128;
        return a[7:0];
    endfunction

    task automatic step(input logic r, input logic v, input logic [7:0] p);
        exp_t e;
        rst_n    = r;
        valid_in = v;
        pixel_in = p;
        if (!r && v) begin
            if (tr >= 2 && tc >= 2) begin
                exp_q.push_back('{cyc + 4, model(tr, tc), tr, tc});
                if (tr == 2 && tc == 2) acc22 = cyc + 1;
            end
            if (tc == N - 1) begin
                tc = 0;
                tr = (tr == N - 1) ? 0 : tr + 1;
            end else begin
                tc = tc + 1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (r) begin
            exp_q.delete();
            tr = 0;
            tc = 0;
            chk("reset_valid_out", {31'd0, valid_out}, 32'd0);
            chk("reset_pixel_out", {24'd0, pixel_out}, 32'd0);
            last_out = 8'd0;
        end else if (valid_out) begin
            if (exp_q.size() == 0) begin
                chk("stray_pulse", {31'd0, valid_out}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("latency_r%0d_c%0d", e.r, e.c), cyc, e.t);
                chk($sformatf("value_r%0d_c%0d", e.r, e.c), {24'd0, pixel_out}, {24'd0, e.val});
                out_img[e.r][e.c] = pixel_out;
                frame_sum += int'(signed'(pixel_out)) * (e.r * N + e.c + 1);
            end
            if (pulses == 0) first_cyc = cyc;
            pulses++;
            last_out = pixel_out;
        end else begin
            chk("hold_pixel_out", {24'd0, pixel_out}, {24'd0, last_out});
            if (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
                e = exp_q.pop_front();
                chk($sformatf("missed_r%0d_c%0d", e.r, e.c), {31'd0, valid_out}, 32'd1);
            end
        end
    endtask

    task automatic clear_stats();
        pulses    = 0;
        frame_sum = 0;
        first_cyc = -1;
    endtask

    task automatic drive(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'b1, 8'(img[k / N][k % N]));
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'(k * 13 + g));
        end
    endtask

    task automatic flush();
        repeat (5) step(1'b0, 1'b0, 8'd0);
        chk("drain", exp_q.size(), 32'd0);
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                img[r][c] = (r * N + c) % 256;
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                img[r][c] = v;
    endtask

    initial begin
        // Reset held three cycles with valid_in toggling
        step(1'b1, 1'b1, 8'd5);
        step(1'b1, 1'b0, 8'd6);
        step(1'b1, 1'b1, 8'd7);

        // Ramp frame, valid every cycle
        fill_ramp();
        clear_stats();
        drive(N * N, 0);
        flush();
        chk("ramp_pulses", pulses, 32'd676);
        chk("first_latency", first_cyc - acc22, 32'd3);
        chk("first_value", {24'd0, out_img[2][2]}, 32'd0);
        chk("pos_sat_centre_8_4", {24'd0, out_img[9][5]}, 32'h7f);
        ramp_sum = frame_sum;

        // Dark centre with bright cross neighbours
        fill_const(0);
        img[9][10]  = 255;
        img[11][10] = 255;
        img[10][9]  = 255;
        img[10][11] = 255;
        clear_stats();
        drive(N * N, 0);
        flush();
        chk("cross_pulses", pulses, 32'd676);
        chk("neg_sat_centre_10_10", {24'd0, out_img[11][11]}, 32'h80);
        chk("pos_sat_centre_9_10", {24'd0, out_img[10][11]}, 32'h7f);

        // Constant image with 1-on/2-off gaps
        fill_const(100);
        clear_stats();
        drive(N * N, 2);
        flush();
        chk("gapped_pulses", pulses, 32'd676);
        chk("gapped_sum", frame_sum, 32'd0);

        // Reset mid-frame after 400 pixels, then a clean ramp frame
        fill_ramp();
        drive(400, 0);
        step(1'b1, 1'b0, 8'd0);
        clear_stats();
        drive(N * N, 0);
        flush();
        chk("post_reset_pulses", pulses, 32'd676);
        chk("post_reset_sum", frame_sum, ramp_sum);

        // Two ramp frames back to back
        clear_stats();
        drive(N * N, 0);
        drive(N * N, 0);
        flush();
        chk("b2b_pulses", pulses, 32'd1352);
        chk("b2b_sum", frame_sum, 2 * ramp_sum);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
